unified_mem: RTL and testbench

Single-ported unified instruction/data memory that acts as the responder for the rv32i core's two memory initiator ports (instruction fetch and load/store). It arbitrates both ports onto one word-wide RAM array, inserts configurable wait states, and signals stalls through per-port busy outputs. It sits between the core and the SoC top, replacing ideal zero-latency memory models in simulation and on FPGA.

---
 rtl/unified_mem.sv | 214 +++++++++++++++++++++
 tb/tb_unified_mem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem.sv
// unified_mem: single-ported word RAM shared by the instruction-fetch and
// load/store ports of the rv32i core. Each port runs a small IDLE/WAIT/READY
// machine that inserts WAIT_STATES cycles after accept. A fixed-priority
// arbiter (data over instruction) grants at most one RAM access per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no request held; port may accept a new strobe
//   ST_WAIT  | request latched; counting down the wait states
//   ST_READY | wait states done; retrying for the RAM grant each cycle
module unified_mem #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_rstrb,
    output logic [31:0] i_rdata,
    output logic        i_rbusy,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_wstrb,
    input  logic        d_rstrb,
    output logic [31:0] d_rdata,
    output logic        d_rbusy,
    output logic        d_wbusy,
    output logic        err
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] LIMIT = {2'b00, BASE_ADDR} + (34'(DEPTH_WORDS) << 2);
    // The counter is loaded one short: the cycle in which it reads zero is
    // itself the grant cycle, so the grant lands WAIT_STATES cycles after accept.
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic        NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } port_state_t;

    function automatic logic in_range(input logic [31:0] a);
        return ({2'b00, a} >= {2'b00, BASE_ADDR}) && ({2'b00, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    port_state_t i_state, i_state_nx;
    port_state_t d_state, d_state_nx;
    logic [3:0]  i_cnt, i_cnt_nx;
    logic [3:0]  d_cnt, d_cnt_nx;

    logic [31:0] i_addr_q;
    logic [31:0] d_addr_q;
    logic [31:0] d_wdata_q;
    logic [3:0]  d_wmask_q;
    logic        d_we_q;

    logic        i_accept, d_accept;
    logic        i_elig, d_elig;
    logic        i_grant, d_grant;

    logic [31:0] i_addr_eff, d_addr_eff, d_wdata_eff;
    logic [3:0]  d_wmask_eff;
    logic        d_we_eff;
    logic        i_in, d_in;
    logic [IDX_W-1:0] i_idx, d_idx, ram_idx;
    logic [31:0] ram_rd;
    logic        ram_we;

    assign i_accept = i_rstrb && !i_rbusy;
    assign d_accept = (d_rstrb || d_wstrb) && !d_rbusy && !d_wbusy;

    // In the accept cycle the request comes straight from the pins so that a
    // zero-wait access can be granted in the same cycle; afterwards the latch.
    assign i_addr_eff  = (i_state == ST_IDLE) ? i_addr  : i_addr_q;
    assign d_addr_eff  = (d_state == ST_IDLE) ? d_addr  : d_addr_q;
    assign d_wdata_eff = (d_state == ST_IDLE) ? d_wdata : d_wdata_q;
    assign d_wmask_eff = (d_state == ST_IDLE) ? d_wmask : d_wmask_q;
    assign d_we_eff    = (d_state == ST_IDLE) ? d_wstrb : d_we_q;

    assign i_in  = in_range(i_addr_eff);
    assign d_in  = in_range(d_addr_eff);
    assign i_idx = word_index(i_addr_eff);
    assign d_idx = word_index(d_addr_eff);

    assign i_elig = (i_state == ST_READY)
                 || ((i_state == ST_WAIT) && (i_cnt == 4'd0))
                 || ((i_state == ST_IDLE) && i_accept && NO_WAIT);
    assign d_elig = (d_state == ST_READY)
                 || ((d_state == ST_WAIT) && (d_cnt == 4'd0))
                 || ((d_state == ST_IDLE) && d_accept && NO_WAIT);

    assign d_grant = d_elig;
    assign i_grant = i_elig && !d_elig;

    assign ram_idx = d_grant ? d_idx : i_idx;
    assign ram_rd  = mem[ram_idx];
    assign ram_we  = !rst && d_grant && d_we_eff && d_in;

    // Instruction port next-state and wait counter.
    always_comb begin
        i_state_nx = i_state;
        i_cnt_nx   = i_cnt;
        case (i_state)
            ST_IDLE: begin
                if (i_accept) begin
                    i_state_nx = NO_WAIT ? ST_READY : ST_WAIT;
                    i_cnt_nx   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (i_cnt == 4'd0) i_state_nx = ST_READY;
                else               i_cnt_nx   = i_cnt - 4'd1;
            end
            ST_READY: i_state_nx = ST_READY;
            default:  i_state_nx = ST_IDLE;
        endcase
        if (i_grant) i_state_nx = ST_IDLE;
    end

    // Data port next-state and wait counter.
    always_comb begin
        d_state_nx = d_state;
        d_cnt_nx   = d_cnt;
        case (d_state)
            ST_IDLE: begin
                if (d_accept) begin
                    d_state_nx = NO_WAIT ? ST_READY : ST_WAIT;
                    d_cnt_nx   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (d_cnt == 4'd0) d_state_nx = ST_READY;
                else               d_cnt_nx   = d_cnt - 4'd1;
            end
            ST_READY: d_state_nx = ST_READY;
            default:  d_state_nx = ST_IDLE;
        endcase
        if (d_grant) d_state_nx = ST_IDLE;
    end

    // Instruction port state, request latch and registered busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state  <= ST_IDLE;
            i_cnt    <= 4'd0;
            i_rbusy  <= 1'b0;
            i_addr_q <= 32'h0;
        end else begin
            i_state <= i_state_nx;
            i_cnt   <= i_cnt_nx;
            i_rbusy <= (i_state_nx != ST_IDLE);
            if (i_accept) i_addr_q <= i_addr;
        end
    end

    // Data port state, request latch and registered busy (read vs write).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state   <= ST_IDLE;
            d_cnt     <= 4'd0;
            d_rbusy   <= 1'b0;
            d_wbusy   <= 1'b0;
            d_addr_q  <= 32'h0;
            d_wdata_q <= 32'h0;
            d_wmask_q <= 4'h0;
            d_we_q    <= 1'b0;
        end else begin
            d_state <= d_state_nx;
            d_cnt   <= d_cnt_nx;
            d_rbusy <= (d_state_nx != ST_IDLE) && !d_we_eff;
            d_wbusy <= (d_state_nx != ST_IDLE) && d_we_eff;
            if (d_accept) begin
                d_addr_q  <= d_addr;
                d_wdata_q <= d_wdata;
                d_wmask_q <= d_wmask;
                d_we_q    <= d_wstrb;
            end
        end
    end

    // RAM byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask_eff[b]) mem[d_idx][8*b +: 8] <= d_wdata_eff[8*b +: 8];
            end
        end
    end

    // Read data capture for the granted port and the sticky range error.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
            err     <= 1'b0;
        end else begin
            if (d_grant && !d_we_eff) d_rdata <= d_in ? ram_rd : 32'h0;
            if (i_grant)              i_rdata <= i_in ? ram_rd : 32'h0;
            if ((d_grant && !d_in) || (i_grant && !i_in)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Bench for unified_mem: two instances (zero-wait at base 0, three-wait at a
// non-zero base) driven by directed steps and random transactions, checked
// against an array model plus latency rules (wait states, one extra cycle
// for the instruction port when both ports request together).
module tb_unified_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr  [2];
    logic        i_rstrb [2];
    logic [31:0] i_rdata [2];
    logic        i_rbusy [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_wmask [2];
    logic        d_wstrb [2];
    logic        d_rstrb [2];
    logic [31:0] d_rdata [2];
    logic        d_rbusy [2];
    logic        d_wbusy [2];
    logic        err     [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [32];
    logic [31:0] last_i [2];
    logic [31:0] last_d [2];
    logic        err_exp [2];

    always #5 clk = ~clk;

    unified_mem #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_addr(i_addr[0]), .i_rstrb(i_rstrb[0]), .i_rdata(i_rdata[0]), .i_rbusy(i_rbusy[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wmask(d_wmask[0]),
        .d_wstrb(d_wstrb[0]), .d_rstrb(d_rstrb[0]), .d_rdata(d_rdata[0]),
        .d_rbusy(d_rbusy[0]), .d_wbusy(d_wbusy[0]), .err(err[0])
    );

    unified_mem #(.DEPTH_WORDS(32), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst),
        .i_addr(i_addr[1]), .i_rstrb(i_rstrb[1]), .i_rdata(i_rdata[1]), .i_rbusy(i_rbusy[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wmask(d_wmask[1]),
        .d_wstrb(d_wstrb[1]), .d_rstrb(d_rstrb[1]), .d_rdata(d_rdata[1]),
        .d_rbusy(d_rbusy[1]), .d_wbusy(d_wbusy[1]), .err(err[1])
    );

    function automatic int ws_of(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    function automatic longint base_of(input int u);
        return (u == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic longint depth_of(input int u);
        return (u == 0) ? 64 : 32;
    endfunction

    function automatic bit in_rng(input int u, input logic [31:0] a);
        longint la = longint'(a);
        return (la >= base_of(u)) && (la < base_of(u) + 4 * depth_of(u));
    endfunction

    function automatic int idx_of(input int u, input logic [31:0] a);
        return int'((longint'(a) - base_of(u)) / 4);
    endfunction

    function automatic logic [31:0] ref_read(input int u, input logic [31:0] a);
        if (!in_rng(u, a)) return 32'h0;
        return (u == 0) ? mem0[idx_of(u, a)] : mem1[idx_of(u, a)];
    endfunction

    task automatic model_write(input int u, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] w;
        if (!in_rng(u, a)) return;
        w = ref_read(u, a);
        for (int b = 0; b < 4; b++)
            if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        if (u == 0) mem0[idx_of(u, a)] = w;
        else        mem1[idx_of(u, a)] = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        for (int u = 0; u < 2; u++) begin
            i_rstrb[u] = 1'b0;
            d_wstrb[u] = 1'b0;
            d_rstrb[u] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int u = 0; u < 2; u++) begin
            chk("rst_i_rdata", i_rdata[u], 32'h0);
            chk("rst_d_rdata", d_rdata[u], 32'h0);
            chk("rst_i_rbusy", i_rbusy[u], 0);
            chk("rst_d_rbusy", d_rbusy[u], 0);
            chk("rst_d_wbusy", d_wbusy[u], 0);
            chk("rst_err",     err[u],     0);
            last_i[u]  = 32'h0;
            last_d[u]  = 32'h0;
            err_exp[u] = 1'b0;
        end
    endtask

    // Called at a falling edge; drives one request (or a pair) for DUT u,
    // waits for all busies to drop and checks latency, data and err.
    task automatic txn(input int u, input bit do_i, input logic [31:0] ia,
                       input bit do_d, input bit dwr, input bit drd,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] wm, input string tag);
        bit is_wr, is_rd, idone, ddone, rb_seen;
        int ic, dc;
        logic [31:0] iexp, dexp;
        is_wr = do_d && dwr;
        is_rd = do_d && !dwr && drd;
        i_addr[u]  = ia;
        i_rstrb[u] = do_i;
        d_addr[u]  = da;
        d_wdata[u] = wd;
        d_wmask[u] = wm;
        d_wstrb[u] = is_wr;
        d_rstrb[u] = do_d && drd;
        dexp = ref_read(u, da);
        if (is_wr) model_write(u, da, wd, wm);
        iexp = ref_read(u, ia);
        if (do_i && !in_rng(u, ia)) err_exp[u] = 1'b1;
        if (do_d && !in_rng(u, da)) err_exp[u] = 1'b1;
        if (do_i)  last_i[u] = iexp;
        if (is_rd) last_d[u] = dexp;
        @(negedge clk);
        clear_strobes();
        idone = !do_i; ddone = !do_d; ic = 0; dc = 0; rb_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (!idone) begin
                if (i_rbusy[u]) ic++; else idone = 1;
            end
            if (is_wr && d_rbusy[u]) rb_seen = 1;
            if (!ddone) begin
                if (is_wr ? d_wbusy[u] : d_rbusy[u]) dc++; else ddone = 1;
            end
            if (idone && ddone) break;
            @(negedge clk);
        end
        chk({tag, "_done"}, {30'h0, idone, ddone}, 32'h3);
        if (do_i) chk({tag, "_i_lat"}, ic, ws_of(u) + (do_d ? 1 : 0));
        if (do_d) chk({tag, "_d_lat"}, dc, ws_of(u));
        if (is_wr) chk({tag, "_rbusy_on_wr"}, rb_seen, 0);
        chk({tag, "_i_rdata"}, i_rdata[u], last_i[u]);
        chk({tag, "_d_rdata"}, d_rdata[u], last_d[u]);
        chk({tag, "_err"}, err[u], err_exp[u]);
    endtask

    function automatic logic [31:0] rand_addr(input int u);
        if ($urandom_range(0, 9) == 0) begin
            if (u == 0) return 32'd256 + 4 * $urandom_range(0, 3);
            return ($urandom_range(0, 1) == 0) ? 32'h0FFC : 32'h1080;
        end
        return 32'(base_of(u)) + $urandom_range(0, 4 * int'(depth_of(u)) - 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_w, a, b;
        int u, op;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; d_wmask[k] = 0;
        end
        clear_strobes();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        for (int w = 0; w < 64; w++)
            txn(0, 0, 0, 1, 1, 0, 32'(4 * w), $urandom, 4'hF, "init0");
        for (int w = 0; w < 32; w++)
            txn(1, 0, 0, 1, 1, 0, 32'h1000 + 32'(4 * w), $urandom, 4'hF, "init1");

        txn(0, 0, 0, 1, 1, 0, 32'h0, 32'h00000013, 4'hF, "w0");
        txn(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, "ifetch0");
        chk("ifetch0_const", i_rdata[0], 32'h00000013);

        txn(0, 0, 0, 1, 1, 0, 32'h8, 32'h11223344, 4'hF, "w8_full");
        txn(0, 0, 0, 1, 1, 0, 32'h8, 32'hAABBCCDD, 4'b0100, "w8_lane2");
        txn(0, 0, 0, 1, 0, 1, 32'h8, 0, 0, "r8");
        chk("r8_const", d_rdata[0], 32'h11BB3344);

        txn(0, 1, 32'h0, 1, 0, 1, 32'h4, 0, 0, "contend");
        chk("contend_i_const", i_rdata[0], 32'h00000013);

        txn(0, 0, 0, 1, 1, 0, 32'h10, 32'h0000006F, 4'hF, "w16");
        txn(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, "ifetch16");
        chk("ifetch16_const", i_rdata[0], 32'h0000006F);

        txn(0, 0, 0, 1, 0, 1, 32'd256, 0, 0, "oor_rd");
        chk("oor_rd_const", d_rdata[0], 32'h0);
        chk("oor_err_const", err[0], 1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        txn(1, 1, 32'h1000, 0, 0, 0, 0, 0, 0, "b_ifetch");
        txn(1, 1, 32'h1004, 1, 0, 1, 32'h1008, 0, 0, "b_contend");
        txn(1, 0, 0, 1, 1, 1, 32'h100C, 32'hCAFE0001, 4'b1001, "b_wr_both");
        txn(1, 0, 0, 1, 0, 1, 32'h100C, 0, 0, "b_rd_back");
        txn(1, 1, 32'h0FFC, 0, 0, 0, 0, 0, 0, "b_oor_below");

        old_w = mem1[5];
        i_addr[1]  = 0;
        d_addr[1]  = 32'h1014;
        d_wdata[1] = ~old_w;
        d_wmask[1] = 4'hF;
        d_wstrb[1] = 1'b1;
        @(negedge clk);
        clear_strobes();
        chk("b_wr_pending", d_wbusy[1], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        repeat (4) @(negedge clk);
        txn(1, 0, 0, 1, 0, 1, 32'h1014, 0, 0, "b_rst_drop");
        chk("b_rst_drop_old", d_rdata[1], old_w);

        for (int n = 0; n < 80; n++) begin
            u  = $urandom_range(0, 1);
            op = $urandom_range(0, 4);
            a  = rand_addr(u);
            b  = rand_addr(u);
            case (op)
                0: txn(u, 0, 0, 1, 1, $urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
                1: txn(u, 0, 0, 1, 0, 1, a, 0, 0, "rnd_rd");
                2: txn(u, 1, b, 0, 0, 0, 0, 0, 0, "rnd_if");
                3: txn(u, 1, b, 1, 0, 1, a, 0, 0, "rnd_both");
                default: txn(u, 1, a, 1, 1, 0, a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr_if");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
